// File: rtl/div_seq_if.sv
// Divider request/response bundle between the EX stage (master) and the
// sequential divider (slave).
interface div_seq_if;
    logic        start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stall_req
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stall_req
    );
endinterface

// File: rtl/div_seq.sv
// Sequential 32-bit DIV/DIVU: radix-2 restoring division, one quotient bit per
// cycle, sign fix-up on completion; result is {remainder, quotient}.
module div_seq (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DIVZERO = 2'b01,
        RUN     = 2'b10,
        DONE    = 2'b11
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*W-1:0]     acc;        // {partial remainder, dividend/quotient}
    logic [W-1:0]       divisor;
    logic               neg_q;
    logic               neg_r;

    logic [W-1:0]       abs_a;
    logic [W-1:0]       abs_b;
    logic [2*W:0]       acc_sh;
    logic [W:0]         trial;
    logic [2*W-1:0]     acc_nxt;
    logic [W-1:0]       q_fin;
    logic [W-1:0]       r_fin;

    // Operand magnitudes for signed mode; unsigned operands pass through.
    always_comb begin
        abs_a = bus.opdata1;
        abs_b = bus.opdata2;
        if (bus.signed_div && bus.opdata1[W-1]) abs_a = ~bus.opdata1 + W'(1);
        if (bus.signed_div && bus.opdata2[W-1]) abs_b = ~bus.opdata2 + W'(1);
    end

    // One restoring step: shift, trial-subtract, keep or restore.
    always_comb begin
        acc_sh  = {acc, 1'b0};
        trial   = acc_sh[2*W:W] - {1'b0, divisor};
        acc_nxt = acc_sh[2*W-1:0];
        if (!trial[W]) acc_nxt = {trial[W-1:0], acc_sh[W-1:1], 1'b1};
        q_fin = neg_q ? (~acc_nxt[W-1:0] + W'(1))   : acc_nxt[W-1:0];
        r_fin = neg_r ? (~acc_nxt[2*W-1:W] + W'(1)) : acc_nxt[2*W-1:W];
    end

    // Freeze the front of the pipe while a divide is being accepted or worked on.
    assign bus.stall_req = !bus.annul &&
                           (((state == IDLE) && bus.start) ||
                            (state == RUN) || (state == DIVZERO));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            divisor    <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            bus.result <= '0;
            bus.ready  <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.annul) begin
                        acc     <= {{W{1'b0}}, abs_a};
                        divisor <= abs_b;
                        neg_q   <= bus.signed_div && (bus.opdata1[W-1] ^ bus.opdata2[W-1]);
                        neg_r   <= bus.signed_div && bus.opdata1[W-1];
                        cnt     <= '0;
                        state   <= (bus.opdata2 == '0) ? DIVZERO : RUN;
                    end
                end
                DIVZERO: begin
                    if (bus.annul) begin
                        state <= IDLE;
                    end else begin
                        bus.result <= '0;
                        bus.ready  <= 1'b1;
                        state      <= DONE;
                    end
                end
                RUN: begin
                    if (bus.annul) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(W - 1)) begin
                            bus.result <= {r_fin, q_fin};
                            bus.ready  <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!bus.start || bus.annul) state <= IDLE;
                    else                         bus.ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized
// divides compared against an arithmetic reference model.
module tb_div_seq;
    logic clk = 1'b0;
    logic rst;
    div_seq_if dif();

    div_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [63:0] last_res = 64'h0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain 64-bit arithmetic, truncation toward zero, zero divisor -> 0.
    function automatic logic [63:0] ref_div(input bit sd, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'h0) return 64'h0;
        if (sd) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'h0, a});
            y = longint'({32'h0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Full request: start held through the divide, optional extra DONE cycles, then release.
    task automatic do_div(input bit sd, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string name);
        logic [63:0] exp;
        int lat;
        exp = ref_div(sd, a, b);
        lat = (b == 32'h0) ? 2 : 33;
        dif.start = 1'b1; dif.signed_div = sd; dif.opdata1 = a; dif.opdata2 = b; dif.annul = 1'b0;
        for (int c = 0; c < lat; c++) begin
            #1;
            checks++;
            if (dif.stall_req !== 1'b1 || dif.ready !== 1'b0) begin
                failures++;
                $display("FAIL %s busy c%0d: stall_req=%b ready=%b, want 1/0", name, c, dif.stall_req, dif.ready);
            end
            next_cycle();
            if (c == 0) begin
                dif.opdata1 = $urandom; dif.opdata2 = $urandom; dif.signed_div = ~sd;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            #1;
            checks++;
            if (dif.ready !== 1'b1 || dif.result !== exp || dif.stall_req !== 1'b0) begin
                failures++;
                $display("FAIL %s done+%0d: ready=%b result=%h stall_req=%b, want 1 %h 0",
                         name, h, dif.ready, dif.result, dif.stall_req, exp);
            end
            if (h < hold) next_cycle();
        end
        dif.start = 1'b0;
        next_cycle();
        #1;
        checks++;
        if (dif.ready !== 1'b0 || dif.result !== exp || dif.stall_req !== 1'b0) begin
            failures++;
            $display("FAIL %s release: ready=%b result=%h stall_req=%b, want 0 %h 0",
                     name, dif.ready, dif.result, dif.stall_req, exp);
        end
        last_res = exp;
    endtask

    // Idle for n cycles with nothing requested; ready must stay low and result hold.
    task automatic quiet(input int n, input logic [63:0] exp, input string name);
        dif.start = 1'b0; dif.annul = 1'b0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            checks++;
            if (dif.ready !== 1'b0 || dif.result !== exp) begin
                failures++;
                $display("FAIL %s quiet%0d: ready=%b result=%h, want 0 %h", name, i, dif.ready, dif.result, exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; dif.start = 1'b0; dif.annul = 1'b0; dif.signed_div = 1'b0;
        dif.opdata1 = 32'h0; dif.opdata2 = 32'h0;
        next_cycle(); next_cycle();
        rst = 1'b0;
        #1;
        checks++;
        if (dif.ready !== 1'b0 || dif.result !== 64'h0 || dif.stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset: ready=%b result=%h stall_req=%b, want 0 0 0", dif.ready, dif.result, dif.stall_req);
        end
        dif.start = 1'b1; dif.annul = 1'b1; dif.opdata2 = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dif.stall_req !== 1'b0 || dif.ready !== 1'b0) begin
                failures++;
                $display("FAIL idle_annul %0d: stall_req=%b ready=%b, want 0 0", i, dif.stall_req, dif.ready);
            end
            next_cycle();
        end
        dif.annul = 1'b0;
    endtask

    task automatic test_directed();
        do_div(1'b0, 32'd100, 32'd7, 0, "divu_100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
        do_div(1'b1, 32'd5, 32'd0, 0, "div_5_0");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_overflow");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0, "divu_max_1");
        do_div(1'b0, 32'd3, 32'hFFFF_FFFF, 0, "divu_small_big");
    endtask

    task automatic test_annul();
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.opdata1 = 32'd1000; dif.opdata2 = 32'd3; dif.annul = 1'b0;
        for (int c = 0; c < 10; c++) next_cycle();
        dif.annul = 1'b1;
        #1;
        checks++;
        if (dif.stall_req !== 1'b0 || dif.ready !== 1'b0) begin
            failures++;
            $display("FAIL annul_run: stall_req=%b ready=%b, want 0 0", dif.stall_req, dif.ready);
        end
        next_cycle();
        dif.start = 1'b0; dif.annul = 1'b0;
        #1;
        checks++;
        if (dif.stall_req !== 1'b0 || dif.ready !== 1'b0 || dif.result !== last_res) begin
            failures++;
            $display("FAIL annul_idle: stall_req=%b ready=%b result=%h, want 0 0 %h",
                     dif.stall_req, dif.ready, dif.result, last_res);
        end
        quiet(40, last_res, "annul_run");
        // Abort in the zero-divisor cycle.
        dif.start = 1'b1; dif.signed_div = 1'b1; dif.opdata1 = 32'd5; dif.opdata2 = 32'd0;
        next_cycle();
        dif.annul = 1'b1;
        next_cycle();
        quiet(5, last_res, "annul_divzero");
        do_div(1'b0, 32'd1000, 32'd3, 0, "after_annul");
    endtask

    task automatic test_reset_mid();
        dif.start = 1'b1; dif.signed_div = 1'b0; dif.opdata1 = 32'd12345; dif.opdata2 = 32'd11; dif.annul = 1'b0;
        for (int c = 0; c < 15; c++) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; dif.start = 1'b0;
        #1;
        checks++;
        if (dif.ready !== 1'b0 || dif.result !== 64'h0 || dif.stall_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b result=%h stall_req=%b, want 0 0 0", dif.ready, dif.result, dif.stall_req);
        end
        quiet(40, 64'h0, "reset_mid");
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0, "divu_after_reset");
    endtask

    task automatic test_back_to_back();
        do_div(1'b0, 32'd20, 32'd6, 3, "hold_done");
        do_div(1'b1, 32'hFFFF_FF00, 32'd0, 2, "hold_divzero");
        do_div(1'b1, 32'hFFFF_FF00, 32'd9, 0, "b2b_a");
        do_div(1'b0, 32'hDEAD_BEEF, 32'h1234, 0, "b2b_b");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit sd;
        for (int i = 0; i < 40; i++) begin
            sd = 1'($urandom_range(0, 1));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            do_div(sd, a, b, int'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  divide request from EX; held high by the pipeline until ready is seen.
REQ-005 signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 opdata1  input  32  dividend; sampled when a request is accepted.
REQ-007 opdata2  input  32  divisor; sampled when a request is accepted.
REQ-008 annul  input  1  abort the current or pending divide (branch flush / exception).
REQ-009 result  output  64  {remainder[63:32], quotient[31:0]} for the HI/LO write.
REQ-010 ready  output  1  result valid this cycle.
REQ-011 stall_req  output  1  request to the stall controller to freeze IF..EX while the divide is in progress.

Function
REQ-012 States SHALL be IDLE, DIVZERO, RUN and DONE, encoded in 2 bits; reset state is IDLE.
REQ-013 Acceptance: in IDLE with start=1 and annul=0 -> latch the operands and signed_div; go to DIVZERO if opdata2==0, else go to RUN with step counter = 0.
REQ-014 In IDLE, start=1 with annul=1 SHALL be ignored; the state SHALL remain IDLE.
REQ-015 Signed mode SHALL latch the magnitudes |opdata1| and |opdata2|, plus neg_q = sign1 XOR sign2 and neg_r = sign1.
REQ-016 Unsigned mode SHALL latch the operands unchanged, with neg_q = neg_r = 0.
REQ-017 RUN SHALL perform one radix-2 restoring step per cycle: shift the 65-bit partial remainder/quotient register left by 1; form a 33-bit trial subtract of the divisor from the upper bits; if the result is non-negative, keep the difference and set quotient bit = 1, else restore and set the bit to 0.
REQ-018 The step counter SHALL be 6 bits and increment once per RUN cycle; after the step with counter==31, RUN SHALL go to DONE, for exactly 32 RUN cycles.
REQ-019 On RUN->DONE, result SHALL be loaded with the quotient negated if neg_q and the remainder negated if neg_r. Negation is two's complement truncated to 32 bits.
REQ-020 DIVZERO SHALL last one cycle, load result = 64'h0 and go to DONE.
REQ-021 In DONE, ready SHALL be 1; DONE SHALL go to IDLE when start=0 or annul=1, else remain in DONE.
REQ-022 annul=1 in RUN or DIVZERO SHALL go to IDLE on the next edge, leave result unchanged, and never assert ready for the aborted request.
REQ-023 Latency: with acceptance at cycle 0 (normal divide), ready=1 in cycle 33; with a zero divisor, ready=1 in cycle 2.
REQ-024 stall_req SHALL be combinational: 1 when (IDLE and start and !annul), or RUN and !annul, or DIVZERO and !annul; otherwise 0. It SHALL be 0 in DONE.
REQ-025 ready SHALL be 1 only in DONE and 0 in all other states.
REQ-026 result SHALL hold its value from DONE until the next RUN->DONE or DIVZERO->DONE load.
REQ-027 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0 (wraps; no trap).
REQ-028 A new request SHALL be accepted only from IDLE; a back-to-back divide therefore needs start to drop for at least one cycle.

Reset
REQ-029 While rst=1, the next state SHALL be IDLE and counter, operand registers and result SHALL be cleared to 0.
REQ-030 After reset, ready=0 and result=0; stall_req SHALL follow REQ-024 (0 unless start=1 in IDLE).
REQ-031 rst SHALL take priority over start and annul, including during RUN; the aborted divide SHALL produce no ready.

Verification
REQ-032 DIVU 100/7, start held -> stall_req=1 in cycles 0..32; ready=1 in cycle 33; result = {32'd2, 32'd14}.
REQ-033 DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF at ready.
REQ-034 DIV 5/0 -> DIVZERO in cycle 1; ready in cycle 2 with result 64'h0.
REQ-035 DIVU 1000/3 with annul=1 in cycle 10 -> IDLE in cycle 11, stall_req=0, ready never 1, result unchanged.
REQ-036 DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-037 rst=1 in cycle 15 of a divide -> IDLE, result 0; then DIVU 0xFFFFFFFF/0x10 -> {32'hF, 32'h0FFFFFFF} 33 cycles after acceptance.
